// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator behind a valid/ready handshake.
// A main + skid register pair gives full throughput with a registered in_ready.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_iword,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  entry_t      r_main;
  entry_t      r_skid;
  entry_t      w_in_entry;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] w_imm32;
  logic [2:0]  w_fmt;
  logic        w_illegal;
  logic        w_accept;
  logic        w_pop;
  logic        w_ld_main_in;
  logic        w_ld_main_skid;
  logic        w_ld_skid;

  // Decode to a 32-bit sign-correct immediate; widened to XLEN below.
  always_comb begin
    w_imm32   = '0;
    w_fmt     = FMT_R;
    w_illegal = 1'b0;
    case (in_iword[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        w_fmt   = FMT_I;
        w_imm32 = {{20{in_iword[31]}}, in_iword[31:20]};
      end
      7'b1110011: begin
        if (in_iword[14]) begin
          w_fmt   = FMT_Z;
          w_imm32 = {27'd0, in_iword[19:15]};
        end else begin
          w_fmt   = FMT_I;
          w_imm32 = {{20{in_iword[31]}}, in_iword[31:20]};
        end
      end
      7'b0100011: begin
        w_fmt   = FMT_S;
        w_imm32 = {{20{in_iword[31]}}, in_iword[31:25], in_iword[11:7]};
      end
      7'b1100011: begin
        w_fmt   = FMT_B;
        w_imm32 = {{19{in_iword[31]}}, in_iword[31], in_iword[7],
                   in_iword[30:25], in_iword[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_fmt   = FMT_U;
        w_imm32 = {in_iword[31:12], 12'd0};
      end
      7'b1101111: begin
        w_fmt   = FMT_J;
        w_imm32 = {{11{in_iword[31]}}, in_iword[31], in_iword[19:12],
                   in_iword[20], in_iword[30:21], 1'b0};
      end
      7'b0110011: w_fmt = FMT_R;
      default: begin
        w_fmt     = FMT_ILL;
        w_illegal = 1'b1;
      end
    endcase
  end

  // zimm is non-negative in 32 bits, so one sign extension covers every format.
  always_comb begin
    w_in_entry         = '0;
    w_in_entry.imm     = XLEN'($signed(w_imm32));
    w_in_entry.fmt     = w_fmt;
    w_in_entry.illegal = w_illegal;
    w_in_entry.tag     = in_tag;
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  // State register; the handshake flags are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Next state and register load controls; flush overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Entry storage; main is cleared on flush so the outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_main <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= w_in_entry;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_main.imm;
  assign out_fmt     = r_main.fmt;
  assign out_illegal = r_main.illegal;
  assign out_tag     = r_main.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors, handshake, flush, XLEN=64.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_iword, in_tag, out_imm, out_tag;
  logic [2:0]  out_fmt;

  logic        rst64, flush64, in64_valid, in64_ready, out64_valid, out64_ready, out64_illegal;
  logic [31:0] in64_iword;
  logic [15:0] in64_tag, out64_tag;
  logic [63:0] out64_imm;
  logic [2:0]  out64_fmt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_iword(in_iword), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(16)) u64 (
    .clk(clk), .rst(rst64), .flush(flush64), .in_valid(in64_valid), .in_ready(in64_ready),
    .in_iword(in64_iword), .in_tag(in64_tag), .out_valid(out64_valid), .out_ready(out64_ready),
    .out_imm(out64_imm), .out_fmt(out64_fmt), .out_illegal(out64_illegal), .out_tag(out64_tag)
  );

  task automatic test_reset();
    rst = 1'b1; rst64 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag} !== {1'b0, 1'b1, 32'd0, 3'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset: got v=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%h, want v=0 rdy=1 all zero",
               out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag);
    end
    rst = 1'b0; rst64 = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_format(input string name, input logic [31:0] word, input logic [31:0] tag,
                             input logic [31:0] eimm, input logic [2:0] efmt, input logic eill);
    @(negedge clk);
    in_valid = 1'b1; in_iword = word; in_tag = tag; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_imm, out_fmt, out_illegal, out_tag} !== {1'b1, eimm, efmt, eill, tag}) begin
      errors++;
      $display("FAIL %s: got v=%b imm=%h fmt=%0d ill=%b tag=%h, want v=1 imm=%h fmt=%0d ill=%b tag=%h",
               name, out_valid, out_imm, out_fmt, out_illegal, out_tag, eimm, efmt, eill, tag);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pop: got out_valid=%b, want 0", name, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, exp_tag = 1, cnt = 0, cyc = 0;
    logic hold = 1'b0;
    logic [64:0] saved = '0;
    logic acc, pop;
    while (exp_tag <= 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checks++;
        if ({out_valid, out_imm, out_tag} !== saved) begin
          errors++;
          $display("FAIL bp_stable: got %h, want %h", {out_valid, out_imm, out_tag}, saved);
        end
      end
      checks++;
      if (in_ready !== (cnt != 2)) begin
        errors++;
        $display("FAIL bp_in_ready: got %b with %0d held, want %b", in_ready, cnt, (cnt != 2));
      end
      in_valid  = (sent < 10);
      in_tag    = 32'(sent + 1);
      in_iword  = {12'(sent + 1), 5'd0, 3'd0, 5'd1, 7'h13};
      out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_valid & in_ready;
      pop = out_valid & out_ready;
      if (pop) begin
        checks++;
        if ({out_tag, out_imm} !== {32'(exp_tag), 32'(exp_tag)}) begin
          errors++;
          $display("FAIL bp_order: got tag=%0d imm=%0d, want %0d", out_tag, out_imm, exp_tag);
        end
        exp_tag++;
      end
      if (acc) sent++;
      cnt  = cnt + int'(acc) - int'(pop);
      hold = out_valid & ~out_ready;
      saved = {out_valid, out_imm, out_tag};
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (exp_tag != 11 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete: got %0d tags out, v=%b, want 10 tags and v=0", exp_tag - 1, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({out_valid, in_ready, out_tag} !== {1'b1, 1'b1, 32'(100 + i - 1)}) begin
          errors++;
          $display("FAIL b2b_%0d: got v=%b rdy=%b tag=%0d, want v=1 rdy=1 tag=%0d",
                   i, out_valid, in_ready, out_tag, 100 + i - 1);
        end
      end
      in_valid  = (i < 8);
      in_tag    = 32'(100 + i);
      in_iword  = 32'h00B50533;
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_tag = 32'd201; in_iword = 32'hFFF00093; out_ready = 1'b0;
    @(negedge clk);
    in_tag = 32'd202;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_tag} !== {1'b1, 1'b0, 32'd201}) begin
      errors++;
      $display("FAIL flush_fill: got v=%b rdy=%b tag=%0d, want v=1 rdy=0 tag=201", out_valid, in_ready, out_tag);
    end
    in_tag = 32'd203; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if ({out_valid, in_ready, out_imm, out_tag} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL flush_clear: got v=%b rdy=%b imm=%h tag=%0d, want v=0 rdy=1 imm=0 tag=0",
               out_valid, in_ready, out_imm, out_tag);
    end
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_ghost: got a flushed entry out (v=1), want none");
    end
    out_ready = 1'b0;
    test_format("flush_resume", 32'h00B50533, 32'd204, 32'd0, 3'd0, 1'b0);
  endtask

  task automatic test_xlen64();
    in64_valid = 1'b0; out64_ready = 1'b0; flush64 = 1'b0;
    @(negedge clk);
    in64_valid = 1'b1; in64_iword = 32'hFE000EE3; in64_tag = 16'h0011;
    @(negedge clk);
    in64_valid = 1'b0;
    checks++;
    if ({out64_valid, out64_imm, out64_fmt} !== {1'b1, 64'hFFFFFFFF_FFFFFFFC, 3'd3}) begin
      errors++;
      $display("FAIL x64_btype: got v=%b imm=%h fmt=%0d, want v=1 imm=fffffffffffffffc fmt=3",
               out64_valid, out64_imm, out64_fmt);
    end
    out64_ready = 1'b1;
    @(negedge clk);
    out64_ready = 1'b0;
    in64_valid = 1'b1; in64_iword = 32'h800000B7; in64_tag = 16'h0012;
    @(negedge clk);
    in64_valid = 1'b0;
    checks++;
    if ({out64_valid, out64_imm, out64_fmt, out64_tag} !== {1'b1, 64'hFFFFFFFF_80000000, 3'd4, 16'h0012}) begin
      errors++;
      $display("FAIL x64_lui: got v=%b imm=%h fmt=%0d tag=%h, want v=1 imm=ffffffff80000000 fmt=4 tag=0012",
               out64_valid, out64_imm, out64_fmt, out64_tag);
    end
    out64_ready = 1'b1;
    @(negedge clk);
    out64_ready = 1'b0;
    in64_valid = 1'b1; in64_iword = 32'hFFF00093; in64_tag = 16'h0055;
    @(negedge clk);
    in64_tag = 16'h0056;
    @(posedge clk);
    #2;
    checks++;
    if ({out64_valid, in64_ready, out64_imm} !== {1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF}) begin
      errors++;
      $display("FAIL x64_full: got v=%b rdy=%b imm=%h, want v=1 rdy=0 imm=all ones", out64_valid, in64_ready, out64_imm);
    end
    rst64 = 1'b1;
    #1;
    checks++;
    if ({out64_valid, in64_ready, out64_imm, out64_tag} !== {1'b1 ^ 1'b1, 1'b1, 64'd0, 16'd0}) begin
      errors++;
      $display("FAIL x64_async_rst: got v=%b rdy=%b imm=%h tag=%h, want v=0 rdy=1 imm=0 tag=0",
               out64_valid, in64_ready, out64_imm, out64_tag);
    end
    in64_valid = 1'b0;
    @(negedge clk);
    rst64 = 1'b0;
    @(negedge clk);
    checks++;
    if ({out64_valid, in64_ready} !== 2'b01) begin
      errors++;
      $display("FAIL x64_no_residual: got v=%b rdy=%b, want v=0 rdy=1", out64_valid, in64_ready);
    end
    in64_valid = 1'b1; in64_iword = 32'h3402D073; in64_tag = 16'h0057;
    @(negedge clk);
    in64_valid = 1'b0;
    checks++;
    if ({out64_valid, out64_imm, out64_fmt, out64_tag} !== {1'b1, 64'd5, 3'd6, 16'h0057}) begin
      errors++;
      $display("FAIL x64_resume: got v=%b imm=%h fmt=%0d tag=%h, want v=1 imm=5 fmt=6 tag=0057",
               out64_valid, out64_imm, out64_fmt, out64_tag);
    end
  endtask

  initial begin
    rst = 1'b1; rst64 = 1'b1; flush = 1'b0; flush64 = 1'b0;
    in_valid = 1'b0; in_iword = '0; in_tag = '0; out_ready = 1'b0;
    in64_valid = 1'b0; in64_iword = '0; in64_tag = '0; out64_ready = 1'b0;
    test_reset();
    test_format("addi", 32'hFFF00093, 32'd1, 32'hFFFFFFFF, 3'd1, 1'b0);
    test_format("sw",   32'hFE112E23, 32'd2, 32'hFFFFFFFC, 3'd2, 1'b0);
    test_format("jal",  32'h800000EF, 32'd3, 32'hFFF00000, 3'd5, 1'b0);
    test_format("lui",  32'h123450B7, 32'd4, 32'h12345000, 3'd4, 1'b0);
    test_format("beq",  32'hFE000EE3, 32'd5, 32'hFFFFFFFC, 3'd3, 1'b0);
    test_format("add",  32'h00B50533, 32'd6, 32'h00000000, 3'd0, 1'b0);
    test_format("csrrwi", 32'h3402D073, 32'd7, 32'h00000005, 3'd6, 1'b0);
    test_format("csrrw",  32'h34001073, 32'd8, 32'h00000340, 3'd1, 1'b0);
    test_format("illegal", 32'h0000007F, 32'd9, 32'h00000000, 3'd7, 1'b1);
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
